// File: rtl/kbd_load_ctrl.sv
// kbd_load_ctrl: scans a 4x4 keypad and debounces one key at a time.
// Each accepted key is converted to the code {row_idx, col_idx} on kbd4..kbd1,
// and the output register receives a one-cycle LoadOut strobe.
// Optional build macro KBD_REPEAT_EN: a key held in RELEASE for REPEAT_CYCLES
// re-enters LOAD, which gives another strobe with the same code.
module kbd_load_ctrl #(
    parameter int SCAN_DIV      = 2,
    parameter int DEB_CYCLES    = 4,
    parameter int REPEAT_CYCLES = 16
) (
    input  logic       MainClock,
    input  logic       invMainReset,
    input  logic       en,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       kbd1,
    output logic       kbd2,
    output logic       kbd3,
    output logic       kbd4,
    output logic       LoadOut
);

    localparam logic [1:0] ST_SCAN    = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_LOAD    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam int DIV_W = $clog2(SCAN_DIV + 1);
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Elaboration-time guard: all timing parameters must be at least one cycle
    if (SCAN_DIV < 1 || DEB_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
        $error("kbd_load_ctrl: SCAN_DIV, DEB_CYCLES and REPEAT_CYCLES must be >= 1");
    end

    // Lowest set row wins when several rows return together
    function automatic logic [1:0] low_row(input logic [3:0] r);
        logic [1:0] idx;
        if (r[0]) begin
            idx = 2'd0;
        end else if (r[1]) begin
            idx = 2'd1;
        end else if (r[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    // One-hot column drive for a column index
    function automatic logic [3:0] col_onehot(input logic [1:0] idx);
        logic [3:0] oh;
        case (idx)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0001;
        endcase
        return oh;
    endfunction

    logic [1:0]       state_r, state_s;
    logic [3:0]       col_r, col_s;
    logic [1:0]       pos_r, pos_s;       // scan position, survives en=0 stalls
    logic [1:0]       next_pos_s;
    logic [DIV_W-1:0] div_r, div_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [1:0]       row_idx_r, row_idx_s;
    logic [3:0]       kbd_r, kbd_s;
    logic             load_r, load_s;
    logic             key_bit_s;
`ifdef KBD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
    logic [REP_W-1:0] rep_r, rep_s;
`endif

    assign next_pos_s = pos_r + 2'd1;
    assign key_bit_s  = row[row_idx_r];

    // Next-state logic for the scan/debounce/load/release sequence
    always_comb begin
        state_s   = state_r;
        col_s     = col_r;
        pos_s     = pos_r;
        div_s     = div_r;
        cnt_s     = cnt_r;
        row_idx_s = row_idx_r;
        kbd_s     = kbd_r;
        load_s    = 1'b0;
`ifdef KBD_REPEAT_EN
        rep_s     = rep_r;
`endif
        case (state_r)
            ST_SCAN: begin
                if (!en) begin
                    // Stall: columns off, divider and position hold
                    col_s = 4'b0000;
                end else if ((col_r != 4'b0000) && (row != 4'b0000)) begin
                    // Column freezes at its current value while the key is qualified
                    row_idx_s = low_row(row);
                    cnt_s     = '0;
                    state_s   = ST_DEBOUNCE;
                end else if (div_r == DIV_LAST) begin
                    div_s = '0;
                    pos_s = next_pos_s;
                    col_s = col_onehot(next_pos_s);
                end else begin
                    // Also restores the held column after an en=0 stall
                    div_s = div_r + DIV_ONE;
                    col_s = col_onehot(pos_r);
                end
            end
            ST_DEBOUNCE: begin
                if (!key_bit_s) begin
                    // Bounce: abandon the key and continue from the next column
                    cnt_s   = '0;
                    div_s   = '0;
                    pos_s   = next_pos_s;
                    col_s   = col_onehot(next_pos_s);
                    state_s = ST_SCAN;
                end else if (cnt_r == CNT_LAST) begin
                    // Code lands together with the strobe so it is stable at the load edge
                    kbd_s   = {row_idx_r, pos_r};
                    load_s  = 1'b1;
                    cnt_s   = '0;
                    state_s = ST_LOAD;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_LOAD: begin
                cnt_s   = '0;
                state_s = ST_RELEASE;
`ifdef KBD_REPEAT_EN
                rep_s   = '0;
`endif
            end
            ST_RELEASE: begin
                if (key_bit_s) begin
                    cnt_s = '0;
`ifdef KBD_REPEAT_EN
                    if (rep_r == REP_LAST) begin
                        rep_s   = '0;
                        load_s  = 1'b1;
                        state_s = ST_LOAD;
                    end else begin
                        rep_s = rep_r + REP_ONE;
                    end
`endif
                end else begin
`ifdef KBD_REPEAT_EN
                    rep_s = '0;
`endif
                    if (cnt_r == CNT_LAST) begin
                        cnt_s   = '0;
                        div_s   = '0;
                        pos_s   = next_pos_s;
                        col_s   = col_onehot(next_pos_s);
                        state_s = ST_SCAN;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
            end
            default: begin
                state_s = ST_SCAN;
                col_s   = 4'b0001;
                pos_s   = 2'd0;
                div_s   = '0;
                cnt_s   = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge MainClock) begin
        if (!invMainReset) begin
            state_r   <= ST_SCAN;
            col_r     <= 4'b0001;
            pos_r     <= 2'd0;
            div_r     <= '0;
            cnt_r     <= '0;
            row_idx_r <= 2'd0;
            kbd_r     <= 4'b0000;
            load_r    <= 1'b0;
`ifdef KBD_REPEAT_EN
            rep_r     <= '0;
`endif
        end else begin
            state_r   <= state_s;
            col_r     <= col_s;
            pos_r     <= pos_s;
            div_r     <= div_s;
            cnt_r     <= cnt_s;
            row_idx_r <= row_idx_s;
            kbd_r     <= kbd_s;
            load_r    <= load_s;
`ifdef KBD_REPEAT_EN
            rep_r     <= rep_s;
`endif
        end
    end

    assign col                      = col_r;
    assign {kbd4, kbd3, kbd2, kbd1} = kbd_r;
    assign LoadOut                  = load_r;

endmodule

// File: tb/tb_kbd_load_ctrl.sv
// Directed bench for kbd_load_ctrl: a keypad model returns rows for the driven
// column; expected codes are queued at key press and popped on each LoadOut.
module tb_kbd_load_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] row;
    logic [3:0] col;
    logic       kbd1, kbd2, kbd3, kbd4;
    logic       load;

    logic [3:0] km [4];          // pressed keys per column: row bits returned when that column is driven
    logic       force_en;
    logic [3:0] force_val;

    int         checks  = 0;
    int         errors  = 0;
    int         strobes = 0;
    logic [3:0] exp_q [$];
    logic [3:0] extra_exp;

    wire [3:0] kbd = {kbd4, kbd3, kbd2, kbd1};

    always #5 clk = ~clk;

    kbd_load_ctrl dut (
        .MainClock    (clk),
        .invMainReset (rst_n),
        .en           (en),
        .row          (row),
        .col          (col),
        .kbd1         (kbd1),
        .kbd2         (kbd2),
        .kbd3         (kbd3),
        .kbd4         (kbd4),
        .LoadOut      (load)
    );

    // Keypad model
    always_comb begin
        row = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            if (col[c]) row = row | km[c];
        end
        if (force_en) row = force_val;
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock; every strobe must match the oldest queued code
    task automatic tick();
        logic [3:0] pend;
        @(posedge clk);
        #1;
        if (load === 1'b1) begin
            strobes++;
            pend = (exp_q.size() > 0) ? 4'd1 : 4'd0;
            chk("strobe_pending", pend, 4'd1);
            if (pend == 4'd1) chk("strobe_code", kbd, exp_q.pop_front());
        end
    endtask

    task automatic wait_col(input logic [3:0] target, input string tag);
        for (int i = 0; i < 20 && col !== target; i++) tick();
        chk(tag, col, target);
    endtask

    task automatic wait_strobe(input string tag);
        int s0;
        s0 = strobes;
        for (int i = 0; i < 60 && strobes == s0; i++) tick();
        chk(tag, 4'(strobes - s0), 4'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s1;
        rst_n     = 1'b0;
        en        = 1'b1;
        force_en  = 1'b1;
        force_val = 4'b1111;
        for (int c = 0; c < 4; c++) km[c] = 4'b0000;

        // Reset held three cycles with all rows high
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_col", col, 4'b0001);
            chk("rst_kbd", kbd, 4'b0000);
            chk("rst_load", {3'b000, load}, 4'b0000);
        end
        rst_n    = 1'b1;
        force_en = 1'b0;
        tick(); chk("scan_start0", col, 4'b0001);
        tick(); chk("scan_start1", col, 4'b0010);

        // en low stalls scanning; resumes at the held column
        en = 1'b0;
        tick(); chk("en_off0", col, 4'b0000);
        tick(); chk("en_off1", col, 4'b0000);
        en = 1'b1;
        tick(); chk("en_resume", col, 4'b0010);
        tick(); chk("en_rotate", col, 4'b0100);

        // Press row 2 on column 1: code 1001 exactly five cycles later
        wait_col(4'b0010, "wait_col1");
        km[1] = 4'b0100;
        exp_q.push_back(4'b1001);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("lat_noload", {3'b000, load}, 4'b0000);
            chk("lat_kbd_old", kbd, 4'b0000);
        end
        tick();
        chk("lat_load", {3'b000, load}, 4'b0001);
        chk("lat_kbd", kbd, 4'b1001);
        km[1] = 4'b0000;
        tick(); chk("load_one_cycle", {3'b000, load}, 4'b0000);
        tick(); tick(); tick();
        chk("release_frozen", col, 4'b0010);
        tick(); chk("release_next_col", col, 4'b0100);

        // Bounce: two high cycles then low, no strobe, continue at next column
        wait_col(4'b0001, "wait_col0");
        km[0] = 4'b0010;
        tick(); tick();
        km[0] = 4'b0000;
        tick();
        chk("bounce_col", col, 4'b0010);
        chk("bounce_kbd", kbd, 4'b1001);
        chk("bounce_load", {3'b000, load}, 4'b0000);

        // Rows 0 and 3 together on column 3: row 0 wins
        km[3] = 4'b1001;
        exp_q.push_back(4'b0011);
        wait_strobe("multi_strobe");
        chk("multi_kbd", kbd, 4'b0011);
        km[3] = 4'b0000;
        repeat (6) tick();

        // Reset during LOAD
        km[2] = 4'b1000;
        exp_q.push_back(4'b1110);
        wait_strobe("rstload_strobe");
        chk("rstload_in_load", {3'b000, load}, 4'b0001);
        rst_n = 1'b0;
        tick();
        chk("rstload_load", {3'b000, load}, 4'b0000);
        chk("rstload_kbd", kbd, 4'b0000);
        chk("rstload_col", col, 4'b0001);
        km[2] = 4'b0000;
        rst_n = 1'b1;
        tick(); chk("rstload_scan0", col, 4'b0001);
        tick(); chk("rstload_scan1", col, 4'b0010);

        // Long hold: auto-repeat strobes only when the repeat feature is built
        km[3] = 4'b0010;
        exp_q.push_back(4'b0111);
`ifdef KBD_REPEAT_EN
        exp_q.push_back(4'b0111);
        exp_q.push_back(4'b0111);
        extra_exp = 4'd2;
`else
        extra_exp = 4'd0;
`endif
        wait_strobe("hold_strobe");
        s1 = strobes;
        repeat (40) tick();
        km[3] = 4'b0000;
        repeat (8) tick();
        chk("repeat_extra", 4'(strobes - s1), extra_exp);
        chk("hold_kbd", kbd, 4'b0111);
        chk("queue_empty", 4'(exp_q.size()), 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
